// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared states, master ids and defaults for the memory bus arbiter
package mem_bus_pkg;

    // Transfer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Master identifiers: M0 is the CPU core, M1 the loader/debug DMA
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Wait-state budget before an access is abandoned with an error
    localparam int DEFAULT_TIMEOUT = 15;

    // The master that did not win the last grant
    function automatic logic other_master(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rtl/mem_bus_arbiter_rr.sv - combinational two-way round-robin grant
module rr_arbiter2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       mask_valid,
    input  logic       mask_id,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic [1:0] eligible;

    // Drop the just-served master, then let the pointer break a tie
    always_comb begin
        eligible = req;
        if (mask_valid) begin
            eligible[mask_id] = 1'b0;
        end
        gnt_valid = |eligible;
        gnt_id    = M0;
        if (eligible == 2'b11) begin
            gnt_id = ptr;
        end else if (eligible[1]) begin
            gnt_id = M1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter for the single memory port
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              mem_err
);

    // Last ACCESS cycle count before the wait-state budget is exhausted
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;

    logic              ptr_q;
    logic              mask_valid_q;
    logic              mask_id_q;
    logic              gnt_q;
    logic              we_q;
    logic [7:0]        cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              gnt_valid;
    logic              gnt_id;
    logic              cnt_last;
    logic              resp0;
    logic              resp1;

    rr_arbiter2 u_rr (
        .req        ({m1_req, m0_req}),
        .ptr        (ptr_q),
        .mask_valid (mask_valid_q),
        .mask_id    (mask_id_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign cnt_last = (cnt_q == CNT_LAST);

    // State register; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus strobe/response decode, all from registered state
    always_comb begin
        state_d  = state_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        resp0    = 1'b0;
        resp1    = 1'b0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_err   = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_rd = !we_q;
                mem_wr = we_q;
                if (mem_ready || cnt_last) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                resp0   = (gnt_q == M0);
                resp1   = (gnt_q == M1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        m0_ack = resp0;
        m1_ack = resp1;
        m0_err = resp0 && err_q;
        m1_err = resp1 && err_q;
        if (resp0) begin
            m0_rdata = rdata_q;
        end
        if (resp1) begin
            m1_rdata = rdata_q;
        end
    end

    // Grant latching, wait-state counting, response capture and fairness bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= M0;
            mask_valid_q <= 1'b0;
            mask_id_q    <= M0;
            gnt_q        <= M0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The served mask only guards the first IDLE cycle after a response
                    mask_valid_q <= 1'b0;
                    if (gnt_valid) begin
                        gnt_q     <= gnt_id;
                        we_q      <= (gnt_id == M1) ? m1_we    : m0_we;
                        mem_addr  <= (gnt_id == M1) ? m1_addr  : m0_addr;
                        mem_wdata <= (gnt_id == M1) ? m1_wdata : m0_wdata;
                        cnt_q     <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        // A ready on the final budget cycle still completes cleanly
                        rdata_q <= we_q ? '0 : mem_rdata;
                        err_q   <= mem_err;
                    end else if (cnt_last) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    ptr_q        <= other_master(gnt_q);
                    mask_valid_q <= 1'b1;
                    mask_id_q    <= gnt_q;
                end
                default: begin
                    mask_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] mrdata;
        logic        merr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_len;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_ready, mem_err;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        exp_q[$];

    int          resp_wait  = 0;
    logic [31:0] resp_rdata = '0;
    logic        resp_err   = 1'b0;

    int          strobe_cnt = 0;
    int          strobe_len = 0;
    int          first_strobe_cyc = 0;
    logic [31:0] addr0, wdata0;
    logic        wr0;
    int          unstable = 0;

    int          acks_total = 0;
    int          acks0 = 0;
    int          acks1 = 0;
    int          ack_cyc = 0;

    vec_t        vecs[6];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Memory model: counts strobe cycles, tracks stability, answers after resp_wait waits
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            strobe_cnt = 0;
            mem_ready  = 1'b0;
            mem_err    = 1'b0;
            mem_rdata  = '0;
        end else if (mem_rd || mem_wr) begin
            if (strobe_cnt == 0) begin
                first_strobe_cyc = cyc;
                addr0    = mem_addr;
                wdata0   = mem_wdata;
                wr0      = mem_wr;
                unstable = 0;
            end else if (mem_addr !== addr0 || mem_wdata !== wdata0 || mem_wr !== wr0) begin
                unstable++;
            end
            if (mem_rd && mem_wr) begin
                unstable++;
            end
            strobe_cnt++;
            strobe_len = strobe_cnt;
            mem_ready  = (resp_wait >= 0) && (strobe_cnt == resp_wait + 1);
            mem_rdata  = mem_ready ? resp_rdata : 32'hBAD0_BAD0;
            mem_err    = mem_ready ? resp_err : 1'b1;
        end else begin
            strobe_cnt = 0;
            mem_ready  = 1'b0;
            mem_err    = 1'b0;
            mem_rdata  = '0;
        end
    end

    // Scoreboard: every ack pops the oldest expectation
    initial forever begin
        exp_t e;
        logic id;
        @(negedge clk);
        if (rst && (m0_ack || m1_ack)) begin
            id = m1_ack;
            ack_cyc = cyc;
            acks_total++;
            if (m0_ack) acks0++;
            if (m1_ack) acks1++;
            check_bit("ack_onehot", m0_ack & m1_ack, 1'b0);
            check_bit("strobe_in_resp", mem_rd | mem_wr, 1'b0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got master %0d expected none", id);
            end else begin
                e = exp_q.pop_front();
                check_bit("ack_master", id, e.id);
                check("ack_rdata", id ? m1_rdata : m0_rdata, e.rdata);
                check_bit("ack_err", id ? m1_err : m0_err, e.err);
                check("idle_master_rdata", id ? m0_rdata : m1_rdata, 32'h0);
                check_bit("idle_master_err", id ? m0_err : m1_err, 1'b0);
            end
        end
    end

    task automatic drive_master(input logic id, input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 1'b0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int n = 0;
        while (acks_total < target && n < budget) begin
            step();
            n++;
        end
        check_bit($sformatf("%s_ack_seen", name), acks_total >= target, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int start;
        resp_wait  = v.wait_n;
        resp_rdata = v.mrdata;
        resp_err   = v.merr;
        start = cyc;
        drive_master(v.id, 1'b1, v.we, v.addr, v.wdata);
        exp_q.push_back('{id: v.id, rdata: v.exp_rdata, err: v.exp_err});
        wait_acks(acks_total + 1, 100, name);
        drive_master(v.id, 1'b0, 1'b0, '0, '0);
        check($sformatf("%s_strobe_len", name), strobe_len, v.exp_len);
        check($sformatf("%s_req_to_strobe", name), first_strobe_cyc - start, 1);
        check($sformatf("%s_strobe_to_ack", name), ack_cyc - first_strobe_cyc, v.exp_len);
        check($sformatf("%s_addr", name), addr0, v.addr);
        check($sformatf("%s_wdata", name), wdata0, v.wdata);
        check_bit($sformatf("%s_dir", name), wr0, v.we);
        check($sformatf("%s_unstable", name), unstable, 0);
        repeat (3) step();
    endtask

    initial begin
        int base;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000,  0, 32'hE3A0_1005, 1'b0, 32'hE3A0_1005, 1'b0,  1};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF,  3, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0,  4};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0000_0000, -1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 15};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0000_0000,  0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1,  1};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0000_0000, 14, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 1'b0, 15};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0300, 32'h0F0F_0F0F,  1, 32'h7777_7777, 1'b0, 32'h0000_0000, 1'b0,  2};

        rst = 1'b0;
        mem_ready = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        drive_master(1'b0, 1'b1, 1'b0, 32'h0000_0020, '0);
        drive_master(1'b1, 1'b1, 1'b0, 32'h0000_0030, '0);
        resp_wait  = 0;
        resp_rdata = 32'hC0DE_0001;
        repeat (2) step();

        check_bit("reset_mem_rd", mem_rd, 1'b0);
        check_bit("reset_mem_wr", mem_wr, 1'b0);
        check_bit("reset_acks", m0_ack | m1_ack, 1'b0);
        check_bit("reset_errs", m0_err | m1_err, 1'b0);
        check("reset_rdata", m0_rdata | m1_rdata, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);

        // Both masters requesting continuously from reset alternate strictly
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{id: logic'(i % 2), rdata: 32'hC0DE_0001, err: 1'b0});
        end
        rst = 1'b1;
        wait_acks(6, 60, "rr");
        drive_master(1'b0, 1'b0, 1'b0, '0, '0);
        drive_master(1'b1, 1'b0, 1'b0, '0, '0);
        check("rr_acks0", acks0, 3);
        check("rr_acks1", acks1, 3);
        repeat (3) step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the second wait cycle of an M1 read abandons it; pointer returns to M0
        resp_wait = -1;
        drive_master(1'b1, 1'b1, 1'b0, 32'h0000_0400, '0);
        begin
            int n = 0;
            while (!(mem_rd && strobe_cnt == 2) && n < 20) begin
                step();
                n++;
            end
        end
        check_bit("rst_reached_wait2", mem_rd && strobe_cnt == 2, 1'b1);
        base = acks_total;
        #1 rst = 1'b0;
        #1;
        check_bit("rst_drops_mem_rd", mem_rd, 1'b0);
        check_bit("rst_no_ack_now", m1_ack, 1'b0);
        drive_master(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        check("rst_no_ack_after", acks_total, base);

        resp_wait  = 0;
        resp_rdata = 32'h0000_0077;
        exp_q.push_back('{id: 1'b0, rdata: 32'h0000_0077, err: 1'b0});
        exp_q.push_back('{id: 1'b1, rdata: 32'h0000_0077, err: 1'b0});
        drive_master(1'b0, 1'b1, 1'b0, 32'h0000_0500, '0);
        drive_master(1'b1, 1'b1, 1'b0, 32'h0000_0600, '0);
        wait_acks(base + 1, 20, "post_rst_m0");
        drive_master(1'b0, 1'b0, 1'b0, '0, '0);
        wait_acks(base + 2, 20, "post_rst_m1");
        drive_master(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) step();

        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single word-wide memory port between two bus masters. M0 is the CPU core's memory interface; M1 is the program loader/debug DMA.
- Sequences each transfer as IDLE → ACCESS → RESP with a req/ack handshake.
- Uses round-robin priority, tolerates memory wait states, and enforces a wait-state timeout that reports an error.
- Sits between the core plus loader and the memory/peripheral decoder.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, maximum ACCESS cycles without mem_ready before error (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- m0_req  in  1  M0 transfer request, held until m0_ack
- m0_we  in  1  M0 write (1) / read (0)
- m0_addr  in  ADDR_W  M0 address
- m0_wdata  in  DATA_W  M0 write data
- m0_rdata  out  DATA_W  M0 read data, valid when m0_ack
- m0_ack  out  1  M0 completion pulse
- m0_err  out  1  M0 error, valid when m0_ack
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as M0 for master 1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory transfer complete
- mem_err  in  1  memory error, valid with mem_ready

Behaviour:
- Reset, asynchronous on rst low:
  - state=IDLE, priority pointer=M0, served-mask cleared, timeout counter=0.
  - All outputs 0 (mem_rd, mem_wr, acks, errs, rdata, mem_addr, mem_wdata).
- Reset mid-ACCESS drops strobes immediately; no ack is issued and the transfer is abandoned.
- IDLE, at each edge:
  - Eligible requesters = reqs, excluding the served-mask master if the mask is set.
  - If any eligible: grant per round-robin (pointer master wins ties); latch addr/wdata/we into mem_addr/mem_wdata and an internal we flag; record the grant id; clear the counter; go ACCESS.
  - Served-mask clears after this first IDLE cycle regardless.
- ACCESS:
  - mem_rd = !we, mem_wr = we, driven from registered state (no comb path from m*_req).
  - Address and data are held stable throughout.
  - On edge with mem_ready=1: capture mem_rdata (reads only; writes return 0) and err = mem_err; go RESP.
  - Else counter += 1. When counter reaches TIMEOUT-1 at an edge with no ready: err=1, rdata=0, go RESP.
  - mem_ready in the same edge as the timeout wins: no error.
- RESP (exactly one cycle):
  - Granted master's ack=1, with rdata/err valid; the other master's ack/err/rdata stay 0.
  - mem_rd/mem_wr = 0.
  - Pointer moves to the non-granted master; served-mask set to the granted master; go IDLE.
- Latency:
  - Req sampled at edge E0 → strobe in cycle after E0.
  - With zero wait states, mem_ready at E1 → ack high E1..E2.
  - Minimum 3 cycles per transfer.
- Masters hold req/addr/wdata/we stable from req rise until ack is seen, and deassert by the edge after ack. The served-mask prevents a duplicate grant.
- Simultaneous requests alternate strictly M0, M1, M0, … when both are continuously asserted. Neither master starves: worst-case wait is one other transfer.
- A req dropped by a master before grant is ignored. A req dropped after grant does not abort the transfer; ack is still pulsed.

Decomposition:
- Package mem_bus_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESP=2'd2
  - master ids M0=1'b0, M1=1'b1
  - default TIMEOUT
- Sub-module rr_arbiter2: combinational two-way round-robin grant from (req[1:0], pointer, mask). Keeps the grant policy separately testable.
- FSM, latches and timeout counter stay in mem_bus_arbiter.

Test Plan:
- M0 read, addr 0x0000_0010, memory ready immediately with 0xE3A0_1005 → mem_rd for 1 cycle; m0_ack one cycle later with m0_rdata=0xE3A0_1005, m0_err=0; m1_ack never.
- M1 write, addr 0x0000_0100, data 0xDEAD_BEEF, mem_ready after 3 wait cycles → mem_wr high 4 cycles with stable addr/data; m1_ack 1 cycle, m1_rdata=0.
- Both reqs held continuously from reset, 6 transfers → grant order M0, M1, M0, M1, M0, M1; one ack per transfer; no back-to-back duplicate grant to the same master.
- M0 read with mem_ready never asserted, TIMEOUT=15 → strobe exactly 15 cycles; m0_ack with m0_err=1, m0_rdata=0; next M1 request serviced normally.
- mem_ready with mem_err=1 on M1 read → m1_ack with m1_err=1. Separately, mem_ready on the final timeout cycle → m1_err=0.
- rst pulled low during ACCESS (2nd wait cycle) → mem_rd drops asynchronously, no ack; after release, a new M0 request wins (pointer=M0).
